elevator_datapath: RTL and testbench
====================================

// Module: elevator_datapath
// PURPOSE
//  Datapath partner of the elevator control FSM: latches floor-call buttons, tracks the car's floor,
//  and returns request_i / request_j_gt_i / request_j_lt_i. Consumes up/down/open from the control FSM.
//  Sits between the button panel and the control FSM, one instance per car.
// PARAMETERS
//  N_FLOORS       8   number of floors, >=2; FW = $clog2(N_FLOORS) is the width of floor
//  RESET_FLOOR    0   floor loaded on reset, < N_FLOORS
//  TRAVEL_CYCLES  16  cycles per floor when ELEV_TRAVEL_TIMER_EN is defined, >=2
// PORTS
//  clk             in   1         system clock, rising edge
//  rst_n           in   1         asynchronous, active-low reset
//  btn             in   N_FLOORS  call buttons, level; bit k = call at floor k
//  up              in   1         from control: move up
//  down            in   1         from control: move down
//  open            in   1         from control: door open at current floor
//  request_i       out  1         pending[floor]
//  request_j_gt_i  out  1         any pending bit above floor
//  request_j_lt_i  out  1         any pending bit below floor
//  floor           out  FW        current floor, registered
//  pending         out  N_FLOORS  latched call register
//  arrive          out  1         1-cycle pulse on the cycle floor changes
//  dir_err         out  1         sticky illegal-command flag
// BEHAVIOUR
//  Reset (async assert, sync release): pending=0, floor=RESET_FLOOR, arrive=0, dir_err=0,
//  travel counter=0, FSM=S_IDLE. The same applies on reset asserted mid-travel.
//  pending update, per cycle: pending <= (pending | btn) & ~(open ? onehot(floor) : 0).
//    Clear has priority over set on the current floor in the same cycle. Other floors set normally.
//  request_* outputs are combinational from the pending and floor registers (0-cycle latency).
//    request_j_gt_i=0 at top floor; request_j_lt_i=0 at floor 0.
//  Move command: mv_up = up & ~down & ~open; mv_dn = down & ~up & ~open.
//    open has priority over motion: no floor change and counter cleared while open=1.
//  dir_err set (sticky until reset) on any of:
//    - up & down together
//    - up at floor N_FLOORS-1
//    - down at floor 0
//  In each of these cases floor holds (saturate, no wrap).
//  FSM S_IDLE: counter=0; a legal mv_up/mv_dn -> S_TRAVEL with the direction latched.
//  FSM S_TRAVEL: counter++ each cycle the latched direction's command is still asserted.
//    - Counter reaches terminal count: floor +/-1, arrive=1 for that cycle, counter=0.
//      Stay in S_TRAVEL if the command is still asserted, else S_IDLE.
//    - Command drops or reverses before terminal count: counter=0, floor unchanged, -> S_IDLE.
//      A reverse starts fresh on the next cycle.
//  A floor change and a btn press for the new floor in the same cycle: the bit is latched.
//    request_i reflects it on the following cycle.
// CONFIGURATION
//  ELEV_TRAVEL_TIMER_EN defined:
//    - terminal count = TRAVEL_CYCLES-1
//    - floor steps TRAVEL_CYCLES cycles after the command is first seen
//  ELEV_TRAVEL_TIMER_EN undefined:
//    - terminal count = 0; floor steps on every cycle a legal command is asserted (1 floor/cycle)
//    - the counter is not instantiated and TRAVEL_CYCLES is ignored
// TESTING (N_FLOORS=8, RESET_FLOOR=0, TRAVEL_CYCLES=4 with timer)
//  1 Reset, then btn=8'h20 for 1 cycle -> pending=8'h20, request_j_gt_i=1, request_i=0, floor=0.
//  2 From floor 0 hold up=1 -> floor 1,2,3,... every 4 cycles (every cycle without the macro).
//    arrive pulses at each step.
//  3 Pending 8'h20, floor=5, open=1 with btn[5]=1 in the same cycle -> pending=8'h00 (clear wins).
//    request_i=0 next cycle.
//  4 up=1 at floor 7 -> floor stays 7, dir_err=1. up=down=1 at floor 3 -> floor 3, dir_err=1.
//  5 up held 2 cycles then dropped (timer on) -> floor unchanged, no arrive.
//    Then down held 4 cycles -> floor-1.
//  6 rst_n=0 mid-travel at floor 4 with pending 8'h81 -> asynchronously floor=0, pending=0,
//    arrive=0, dir_err=0.

Source files
------------

// File: rtl/elevator_datapath_if.sv
// elevator_datapath_if
//   Bundles the signals between one elevator car's datapath and its
//   surroundings (button panel and control FSM).
//   master : drives btn/up/down/open, observes the datapath status
//   slave  : the datapath itself
//   Signals:
//     btn            N_FLOORS  call buttons, level, bit k = call at floor k
//     up/down/open   1         commands from the control FSM
//     request_i      1         pending call at the current floor
//     request_j_gt_i 1         any pending call above the current floor
//     request_j_lt_i 1         any pending call below the current floor
//     floor          FW        current floor
//     pending        N_FLOORS  latched call register
//     arrive         1         one-cycle pulse when floor changes
//     dir_err        1         sticky illegal-command flag
interface elevator_datapath_if #(
  parameter int N_FLOORS = 8
);
  localparam int FW = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1;

  logic [N_FLOORS-1:0] btn;
  logic                up;
  logic                down;
  logic                open;
  logic                request_i;
  logic                request_j_gt_i;
  logic                request_j_lt_i;
  logic [FW-1:0]       floor;
  logic [N_FLOORS-1:0] pending;
  logic                arrive;
  logic                dir_err;

  modport master (
    output btn, up, down, open,
    input  request_i, request_j_gt_i, request_j_lt_i, floor, pending, arrive, dir_err
  );

  modport slave (
    input  btn, up, down, open,
    output request_i, request_j_gt_i, request_j_lt_i, floor, pending, arrive, dir_err
  );
endinterface

// File: rtl/elevator_datapath.sv
// elevator_datapath
//   Datapath partner of the elevator control FSM for one car: latches floor
//   calls, tracks the car's floor and reports where pending calls lie relative
//   to the car.
//   Ports:
//     clk    in  system clock, rising edge
//     rst_n  in  asynchronous active-low reset (synchronous release expected)
//     bus    elevator_datapath_if.slave (btn/up/down/open in; request_i,
//            request_j_gt_i, request_j_lt_i, floor, pending, arrive, dir_err out)
//   Configuration macro:
//     ELEV_TRAVEL_TIMER_EN  when defined, a floor step needs TRAVEL_CYCLES
//                           consecutive cycles of a legal command; when
//                           undefined the car steps one floor per cycle and
//                           no travel counter exists.
module elevator_datapath #(
  parameter int N_FLOORS      = 8,
  parameter int RESET_FLOOR   = 0,
  parameter int TRAVEL_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  elevator_datapath_if.slave  bus
);

  localparam int FW = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1;
  localparam logic [FW-1:0] TOP_FLOOR = FW'(N_FLOORS - 1);
  localparam logic [FW-1:0] BOT_FLOOR = {FW{1'b0}};
  localparam logic [FW-1:0] RST_FLOOR = FW'(RESET_FLOOR);
  localparam logic [N_FLOORS-1:0] ONE_HOT0 = {{(N_FLOORS-1){1'b0}}, 1'b1};

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_TRAVEL = 1'b1;

  // Reject nonsensical parameter sets at elaboration time.
  generate
    if (N_FLOORS < 2 || RESET_FLOOR < 0 || RESET_FLOOR >= N_FLOORS || TRAVEL_CYCLES < 2) begin : g_bad_params
      $error("elevator_datapath: illegal parameter combination");
    end
  endgenerate

  logic [N_FLOORS-1:0] pending_r;
  logic [FW-1:0]       floor_r;
  logic                arrive_r;
  logic                dir_err_r;
  logic [0:0]          state_r;
  logic                dir_up_r;

  logic                up_cmd_s;
  logic                dn_cmd_s;
  logic                leg_up_s;
  logic                leg_dn_s;
  logic                err_s;
  logic                go_s;
  logic                step_s;
  logic                dir_nxt_s;
  logic [0:0]          state_nxt_s;
  logic                tc_hit_s;
  logic [N_FLOORS-1:0] clr_mask_s;
  logic                gt_s;
  logic                lt_s;

  // open overrides motion; a simultaneous up+down is no command at all.
  assign up_cmd_s = bus.up & ~bus.down & ~bus.open;
  assign dn_cmd_s = bus.down & ~bus.up & ~bus.open;
  // Saturate at the shaft ends: a command pointing off the end never moves the car.
  assign leg_up_s = up_cmd_s & (floor_r != TOP_FLOOR);
  assign leg_dn_s = dn_cmd_s & (floor_r != BOT_FLOOR);
  assign err_s    = (bus.up & bus.down)
                  | (bus.up & (floor_r == TOP_FLOOR))
                  | (bus.down & (floor_r == BOT_FLOOR));

  assign clr_mask_s = bus.open ? (ONE_HOT0 << floor_r) : {N_FLOORS{1'b0}};

`ifdef ELEV_TRAVEL_TIMER_EN
  localparam int CW = $clog2(TRAVEL_CYCLES);
  localparam logic [CW-1:0] TERM_CNT = CW'(TRAVEL_CYCLES - 1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_cur_s;

  // The accepting cycle in S_IDLE counts as the first travel cycle, so the
  // car steps on the TRAVEL_CYCLES-th consecutive cycle of the command.
  assign cnt_cur_s = (state_r == S_TRAVEL) ? cnt_r : {CW{1'b0}};
  assign tc_hit_s  = (cnt_cur_s == TERM_CNT);

  // Travel counter: counts while moving, cleared on a step or when motion stops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (go_s && !tc_hit_s) begin
      cnt_r <= cnt_cur_s + CW'(1);
    end else begin
      cnt_r <= {CW{1'b0}};
    end
  end
`else
  assign tc_hit_s = 1'b1;
`endif

  // Motion FSM next state: keep travelling only while the latched direction stays legal.
  always_comb begin
    go_s      = 1'b0;
    dir_nxt_s = dir_up_r;
    case (state_r)
      S_IDLE: begin
        if (leg_up_s || leg_dn_s) begin
          go_s      = 1'b1;
          dir_nxt_s = leg_up_s;
        end else begin
          go_s      = 1'b0;
          dir_nxt_s = dir_up_r;
        end
      end
      S_TRAVEL: begin
        if (dir_up_r ? leg_up_s : leg_dn_s) begin
          go_s = 1'b1;
        end else begin
          go_s = 1'b0;
        end
      end
      default: begin
        go_s      = 1'b0;
        dir_nxt_s = dir_up_r;
      end
    endcase
    // A reversal lands here with go_s=0 and is picked up fresh from S_IDLE.
    step_s      = go_s & tc_hit_s;
    state_nxt_s = go_s ? S_TRAVEL : S_IDLE;
  end

  // State, floor, call latch and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      dir_up_r  <= 1'b0;
      floor_r   <= RST_FLOOR;
      pending_r <= {N_FLOORS{1'b0}};
      arrive_r  <= 1'b0;
      dir_err_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      dir_up_r  <= dir_nxt_s;
      // Clear of the current floor wins over a simultaneous press there.
      pending_r <= (pending_r | bus.btn) & ~clr_mask_s;
      arrive_r  <= step_s;
      dir_err_r <= dir_err_r | err_s;
      if (step_s) begin
        floor_r <= dir_nxt_s ? (floor_r + FW'(1)) : (floor_r - FW'(1));
      end else begin
        floor_r <= floor_r;
      end
    end
  end

  // Split the call register into "above" and "below" the current floor.
  always_comb begin
    gt_s = 1'b0;
    lt_s = 1'b0;
    for (int k = 0; k < N_FLOORS; k++) begin
      if (k > int'(floor_r)) begin
        gt_s = gt_s | pending_r[k];
      end else if (k < int'(floor_r)) begin
        lt_s = lt_s | pending_r[k];
      end else begin
        gt_s = gt_s;
        lt_s = lt_s;
      end
    end
  end

  assign bus.request_i      = pending_r[floor_r];
  assign bus.request_j_gt_i = gt_s;
  assign bus.request_j_lt_i = lt_s;
  assign bus.floor          = floor_r;
  assign bus.pending        = pending_r;
  assign bus.arrive         = arrive_r;
  assign bus.dir_err        = dir_err_r;

endmodule

// File: tb/tb_elevator_datapath.sv
module tb_elevator_datapath;
  localparam int N  = 8;
  localparam int TC = 4;
`ifdef ELEV_TRAVEL_TIMER_EN
  localparam int T = TC;
`else
  localparam int T = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  elevator_datapath_if #(.N_FLOORS(N)) bus();

  elevator_datapath #(
    .N_FLOORS(N), .RESET_FLOOR(0), .TRAVEL_CYCLES(TC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  // Reference model: floor as an integer, run = consecutive cycles of the
  // same legal direction since the last step, dir = +1/-1/0.
  int         m_floor;
  int         m_run;
  int         m_dir;
  logic [7:0] m_pend;
  bit         m_arrive;
  bit         m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_floor = 0; m_run = 0; m_dir = 0; m_pend = 8'h00; m_arrive = 1'b0; m_err = 1'b0;
  endfunction

  function automatic void model_step(input logic [7:0] b, input logic u, input logic d, input logic o);
    int want;
    want = 0;
    if (u && d) m_err = 1'b1;
    if (u && m_floor == N - 1) m_err = 1'b1;
    if (d && m_floor == 0) m_err = 1'b1;
    if (!o && u && !d && m_floor < N - 1) want = 1;
    if (!o && d && !u && m_floor > 0) want = -1;
    m_pend = (m_pend | b) & ~(o ? (8'h01 << m_floor) : 8'h00);
    m_arrive = 1'b0;
    if (want == 0 || (m_dir != 0 && want != m_dir)) begin
      m_run = 0;
      m_dir = 0;
    end else begin
      m_dir = want;
      m_run = m_run + 1;
      if (m_run == T) begin
        m_floor  = m_floor + want;
        m_arrive = 1'b1;
        m_run    = 0;
      end
    end
  endfunction

  function automatic bit exp_gt();
    return (m_floor == N - 1) ? 1'b0 : ((m_pend >> (m_floor + 1)) != 8'h00);
  endfunction

  function automatic bit exp_lt();
    return (m_floor == 0) ? 1'b0 : ((m_pend & ((8'h01 << m_floor) - 8'h01)) != 8'h00);
  endfunction

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("floor",   bus.floor,          m_floor);
      chk("pending", bus.pending,        m_pend);
      chk("arrive",  bus.arrive,         m_arrive);
      chk("dir_err", bus.dir_err,        m_err);
      chk("req_i",   bus.request_i,      m_pend[m_floor]);
      chk("req_gt",  bus.request_j_gt_i, exp_gt());
      chk("req_lt",  bus.request_j_lt_i, exp_lt());
    end
  end

  task automatic cycle(input logic [7:0] b, input logic u, input logic d, input logic o);
    bus.btn = b; bus.up = u; bus.down = d; bus.open = o;
    @(posedge clk);
    if (rst_n) model_step(b, u, d, o);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    bus.btn = 8'h00; bus.up = 1'b0; bus.down = 1'b0; bus.open = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic go_to(input int tgt);
    int g;
    g = 0;
    while (m_floor != tgt && g < 200) begin
      if (tgt > m_floor) cycle(8'h00, 1'b1, 1'b0, 1'b0);
      else               cycle(8'h00, 1'b0, 1'b1, 1'b0);
      g++;
    end
    chk("go_to_floor", bus.floor, tgt);
    cycle(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int hold;
    int sel;
    logic u, d, o;
    logic [7:0] b;
    int f0;

    bus.btn = 8'h00; bus.up = 1'b0; bus.down = 1'b0; bus.open = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_floor",   bus.floor,   0);
    chk("rst_pending", bus.pending, 8'h00);
    chk("rst_arrive",  bus.arrive,  0);
    rst_n = 1'b1;
    check_en = 1'b1;

    // 1: a single-cycle call above the car
    cycle(8'h20, 1'b0, 1'b0, 1'b0);
    chk("t1_pending", bus.pending, 8'h20);
    chk("t1_gt",      bus.request_j_gt_i, 1);
    chk("t1_req_i",   bus.request_i, 0);
    chk("t1_floor",   bus.floor, 0);

    // 2: hold up, one floor every T cycles with an arrive pulse
    for (int s = 1; s <= 3; s++) begin
      repeat (T) cycle(8'h00, 1'b1, 1'b0, 1'b0);
      chk("t2_floor",  bus.floor,  s);
      chk("t2_arrive", bus.arrive, 1);
    end

    // 3: open at floor 5 while pressing 5 -> clear wins
    go_to(5);
    cycle(8'h20, 1'b0, 1'b0, 1'b1);
    chk("t3_pending", bus.pending, 8'h00);
    chk("t3_req_i",   bus.request_i, 0);
    chk("t3_floor",   bus.floor, 5);

    // 4: up at the top floor, then up+down at floor 3
    go_to(7);
    cycle(8'h00, 1'b1, 1'b0, 1'b0);
    chk("t4_top_floor", bus.floor, 7);
    chk("t4_top_err",   bus.dir_err, 1);
    cycle(8'hFF, 1'b0, 1'b0, 1'b0);
    chk("t4_top_gt", bus.request_j_gt_i, 0);
    chk("t4_top_lt", bus.request_j_lt_i, 1);
    do_reset();
    chk("t4_err_cleared", bus.dir_err, 0);
    go_to(3);
    cycle(8'h00, 1'b1, 1'b1, 1'b0);
    chk("t4_both_floor", bus.floor, 3);
    chk("t4_both_err",   bus.dir_err, 1);
    cycle(8'h01, 1'b0, 1'b0, 1'b0);
    go_to(0);
    chk("t4_bot_lt", bus.request_j_lt_i, 0);

    // 5: short up burst, then down for 4 cycles
    do_reset();
    go_to(2);
    f0 = 0;
    repeat (2) begin
      cycle(8'h00, 1'b1, 1'b0, 1'b0);
      f0 = f0 + int'(bus.arrive);
    end
    cycle(8'h00, 1'b0, 1'b0, 1'b0);
`ifdef ELEV_TRAVEL_TIMER_EN
    chk("t5_short_floor",  bus.floor, 2);
    chk("t5_short_arrive", f0, 0);
`else
    chk("t5_short_floor",  bus.floor, 4);
    chk("t5_short_arrive", f0, 2);
`endif
    repeat (4) cycle(8'h00, 1'b0, 1'b1, 1'b0);
`ifdef ELEV_TRAVEL_TIMER_EN
    chk("t5_down_floor",  bus.floor, 1);
    chk("t5_down_arrive", bus.arrive, 1);
`else
    chk("t5_down_floor",  bus.floor, 0);
`endif

    // 6: asynchronous reset while travelling from floor 4
    go_to(4);
    cycle(8'h81, 1'b1, 1'b1, 1'b0);
    cycle(8'h00, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_floor",   bus.floor,   0);
    chk("t6_pending", bus.pending, 8'h00);
    chk("t6_arrive",  bus.arrive,  0);
    chk("t6_err",     bus.dir_err, 0);
    bus.up = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the model
    hold = 0;
    u = 1'b0; d = 1'b0; o = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        sel = $urandom_range(0, 9);
        u = (sel <= 3) || (sel == 9);
        d = (sel >= 4 && sel <= 7) || (sel == 9);
        o = (sel == 8);
        hold = $urandom_range(1, 2 * T + 2);
      end
      hold--;
      b = ($urandom_range(0, 3) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      cycle(b, u, d, o | ($urandom_range(0, 15) == 0));
      if (i % 400 == 399) do_reset();
    end

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
